// File: rtl/gate_sweep_bist.sv
// gate_sweep_bist: exhaustive sweep BIST for an N-input reduction gate.
//   Drives every vector 0..2^WIDTH-1 on drive_out. Each vector is held
//   SETTLE+1 cycles, and dut_out is compared with the expected AND/OR/XOR/NAND
//   value in the vector's last cycle. The block counts mismatches, captures the
//   first failing vector and reports pass/done.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   start, op_mode    sweep request, expected function (0 AND,1 OR,2 XOR,3 NAND)
//   drive_out         stimulus to the gate under test
//   dut_out           gate output under test
//   busy, done, pass  sweep status; done is a one-cycle pulse
//   err_count         mismatch count (WIDTH+1 bits, max 2^WIDTH)
//   first_fail_vec/_valid  first mismatching vector
// Optional build macro STOP_ON_FAIL_EN: abort the sweep on the first mismatch.
module gate_sweep_bist #(
  parameter int WIDTH  = 3,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op_mode,
  output logic [WIDTH-1:0] drive_out,
  input  logic             dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH:0]   err_count,
  output logic [WIDTH-1:0] first_fail_vec,
  output logic             first_fail_valid
);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CHECK, S_DONE} state_t;

  typedef struct packed {
    state_t           st;
    logic [1:0]       op;
    logic [WIDTH-1:0] drive;
    logic [3:0]       cnt;
    logic             busy;
    logic             done;
    logic             pass;
    logic [WIDTH:0]   err;
    logic [WIDTH-1:0] ffv;
    logic             ffval;
  } regs_t;

  localparam logic [3:0] CNT_LAST = 4'(SETTLE - 1);

  regs_t r_q, r_d;
  logic  expect_v;
  logic  mism;

  always_comb begin
    expect_v = 1'b0;
    case (r_q.op)
      2'd0: expect_v = &r_q.drive;
      2'd1: expect_v = |r_q.drive;
      2'd2: expect_v = ^r_q.drive;
      default: expect_v = ~&r_q.drive;
    endcase
  end

  assign mism = (dut_out != expect_v);

  always_comb begin
    r_d      = r_q;
    r_d.done = 1'b0;
    case (r_q.st)
      S_IDLE: begin
        if (start) begin
          r_d.op    = op_mode;
          r_d.drive = '0;
          r_d.err   = '0;
          r_d.pass  = 1'b0;
          r_d.ffval = 1'b0;
          r_d.ffv   = '0;
          r_d.busy  = 1'b1;
          r_d.cnt   = '0;
          r_d.st    = S_SETTLE;
        end
      end
      S_SETTLE: begin
        r_d.cnt = r_q.cnt + 4'd1;
        if (r_q.cnt == CNT_LAST) r_d.st = S_CHECK;
      end
      S_CHECK: begin
        r_d.cnt = '0;
`ifdef STOP_ON_FAIL_EN
        if (mism) begin
          // drive_out is left on the failing vector for inspection
          r_d.err   = (WIDTH+1)'(1);
          r_d.ffv   = r_q.drive;
          r_d.ffval = 1'b1;
          r_d.st    = S_DONE;
        end else if (&r_q.drive) begin
          r_d.st = S_DONE;
        end else begin
          r_d.drive = r_q.drive + WIDTH'(1);
          r_d.st    = S_SETTLE;
        end
`else
        if (mism) begin
          r_d.err = r_q.err + (WIDTH+1)'(1);
          if (!r_q.ffval) begin
            r_d.ffv   = r_q.drive;
            r_d.ffval = 1'b1;
          end
        end
        // the sweep ends on all-ones, so drive_out never wraps back to zero
        if (&r_q.drive) begin
          r_d.st = S_DONE;
        end else begin
          r_d.drive = r_q.drive + WIDTH'(1);
          r_d.st    = S_SETTLE;
        end
`endif
      end
      default: begin
        // err already includes the final CHECK update here
        r_d.done = 1'b1;
        r_d.busy = 1'b0;
        r_d.pass = (r_q.err == '0);
        r_d.st   = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '{st: S_IDLE, op: 2'd0, drive: '0, cnt: '0, busy: 1'b0, done: 1'b0,
               pass: 1'b0, err: '0, ffv: '0, ffval: 1'b0};
    end else begin
      r_q <= r_d;
    end
  end

  assign drive_out        = r_q.drive;
  assign busy             = r_q.busy;
  assign done             = r_q.done;
  assign pass             = r_q.pass;
  assign err_count        = r_q.err;
  assign first_fail_vec   = r_q.ffv;
  assign first_fail_valid = r_q.ffval;

endmodule

// File: tb/tb_gate_sweep_bist.sv
// Scoreboard bench for gate_sweep_bist (WIDTH=3). The driver pushes the
// hand-computed result of each sweep; the monitor pops it on every done pulse.
module tb_gate_sweep_bist;

  localparam int W = 3;
`ifdef STOP_ON_FAIL_EN
  localparam int S = 2;
`else
  localparam int S = 1;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op_mode = 2'd0;
  logic [W-1:0] drive_out;
  logic         dut_out;
  logic         busy, done, pass;
  logic [W:0]   err_count;
  logic [W-1:0] first_fail_vec;
  logic         first_fail_valid;

  gate_sweep_bist #(.WIDTH(W), .SETTLE(S)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_mode(op_mode),
    .drive_out(drive_out), .dut_out(dut_out), .busy(busy), .done(done),
    .pass(pass), .err_count(err_count), .first_fail_vec(first_fail_vec),
    .first_fail_valid(first_fail_valid)
  );

  always #5 clk = ~clk;

  // gate model: 0 ideal AND, 1 stuck-at-0, 2 stuck-at-1, 3 ideal NAND
  int dmode = 0;
  always_comb begin
    case (dmode)
      0: dut_out = &drive_out;
      1: dut_out = 1'b0;
      2: dut_out = 1'b1;
      default: dut_out = ~&drive_out;
    endcase
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int err; int ffv; int ffval; int pass; int drv; int lat; int acc;
  } exp_t;
  exp_t sbq[$];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // monitor
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d expected none", cyc);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("latency", cyc - e.acc, e.lat);
        chk("err_count", int'(err_count), e.err);
        chk("first_fail_vec", int'(first_fail_vec), e.ffv);
        chk("first_fail_valid", int'(first_fail_valid), e.ffval);
        chk("pass", int'(pass), e.pass);
        chk("drive_out", int'(drive_out), e.drv);
        chk("busy_at_done", int'(busy), 0);
      end
    end
  end

  task automatic do_start(input logic [1:0] m, input int push, input exp_t e);
    @(negedge clk);
    op_mode = m;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    e.acc = cyc;
    if (push != 0) sbq.push_back(e);
  endtask

  task automatic wait_empty(input string name);
    int ok = 0;
    for (int i = 0; i < 300; i++) begin
      if (sbq.size() == 0) begin ok = 1; break; end
      @(negedge clk);
    end
    if (ok == 0) begin
      chk({name, "_timeout"}, 0, 1);
      sbq.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  function automatic exp_t mk(int err, int ffv, int ffval, int ps, int drv, int lat);
    exp_t e;
    e.err = err; e.ffv = ffv; e.ffval = ffval; e.pass = ps; e.drv = drv; e.lat = lat;
    e.acc = 0;
    return e;
  endfunction

  initial begin
    #12;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err_count), 0);
    chk("rst_drive", int'(drive_out), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

`ifdef STOP_ON_FAIL_EN
    // AND, stuck-at-1: vector 0 fails, done after (0+1)*(2+1)+1 = 4 edges
    dmode = 2;
    do_start(2'd0, 1, mk(1, 0, 1, 0, 0, 4));
    chk("busy_after_start", int'(busy), 1);
    wait_empty("stop_fail");
    // ideal AND runs the full sweep: 8*3+1 = 25 edges
    dmode = 0;
    do_start(2'd0, 1, mk(0, 0, 0, 1, 7, 25));
    wait_empty("stop_pass");
`else
    // ideal AND: full sweep 8*2+1 = 17 edges, clean
    dmode = 0;
    do_start(2'd0, 1, mk(0, 0, 0, 1, 7, 17));
    chk("busy_after_start", int'(busy), 1);
    wait_empty("and_ideal");
    chk("pass_held", int'(pass), 1);

    // stuck-at-0 vs AND: only vector 7 expects 1
    dmode = 1;
    do_start(2'd0, 1, mk(1, 7, 1, 0, 7, 17));
    wait_empty("and_sa0");

    // stuck-at-0 vs XOR: vectors 1,2,4,7 expect 1
    do_start(2'd2, 1, mk(4, 1, 1, 0, 7, 17));
    wait_empty("xor_sa0");

    // ideal NAND: previous failure results cleared at start
    dmode = 3;
    do_start(2'd3, 1, mk(0, 0, 0, 1, 7, 17));
    chk("ffval_cleared_at_start", int'(first_fail_valid), 0);
    wait_empty("nand_ideal");

    // extra start and op_mode change mid-sweep are ignored
    dmode = 0;
    do_start(2'd0, 1, mk(0, 0, 0, 1, 7, 17));
    repeat (4) @(negedge clk);
    start = 1'b1; op_mode = 2'd2;
    @(negedge clk);
    start = 1'b0; op_mode = 2'd1;
    wait_empty("ignore_start");

    // reset mid-sweep: async clear, no done
    do_start(2'd0, 0, mk(0, 0, 0, 0, 0, 0));
    repeat (8) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", int'(busy), 0);
    chk("arst_drive", int'(drive_out), 0);
    chk("arst_err", int'(err_count), 0);
    chk("arst_ffval", int'(first_fail_valid), 0);
    chk("arst_pass", int'(pass), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);

    // stuck-at-1 vs AND: vectors 0..6 fail
    dmode = 2;
    do_start(2'd0, 1, mk(7, 0, 1, 0, 7, 17));
    wait_empty("and_sa1");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
